jump_redirect_arb: RTL

Parametrised successor of the dual-way jump controller. It resolves jump/branch redirects from WAYS execution ways by program age. It drives per-way flush strobes for wrong-path instructions younger than the chosen jump. It holds the oldest redirect in a register until the fetch unit accepts it with a valid/ready handshake. Sits between the execute-unit writeback ports and the front-end PC/fetch redirect input.

---
 rtl/jump_redirect_arb_if.sv | 29 ++
 rtl/jump_redirect_arb.sv | 108 ++++++++++
 2 files changed

// File: rtl/jump_redirect_arb_if.sv
// Bus bundle between the execute-unit writeback ports and the fetch redirect path.
// The arbiter uses the slave modport and the driving side uses the master modport.
interface jump_redirect_arb_if #(
  parameter int WAYS    = 2,
  parameter int ADDR_W  = 32,
  parameter int AGE_W   = 2,
  parameter int EPOCH_W = 3
);
  logic [WAYS-1:0]        way_jumpFlag_i;
  logic [WAYS*ADDR_W-1:0] way_jumpAddr_i;
  logic [WAYS*AGE_W-1:0]  way_age_i;
  logic [AGE_W-1:0]       headAge_i;
  logic                   flush_i;
  logic [WAYS-1:0]        way_jumpClear_o;
  logic                   redirect_valid_o;
  logic [ADDR_W-1:0]      redirect_addr_o;
  logic                   redirect_ready_i;
  logic [EPOCH_W-1:0]     epoch_o;

  modport slave (
    input  way_jumpFlag_i, way_jumpAddr_i, way_age_i, headAge_i, flush_i, redirect_ready_i,
    output way_jumpClear_o, redirect_valid_o, redirect_addr_o, epoch_o
  );

  modport master (
    output way_jumpFlag_i, way_jumpAddr_i, way_age_i, headAge_i, flush_i, redirect_ready_i,
    input  way_jumpClear_o, redirect_valid_o, redirect_addr_o, epoch_o
  );
endinterface

// File: rtl/jump_redirect_arb.sv
// Age-ordered jump redirect arbiter: picks the oldest taken jump across the ways,
// flushes younger wrong-path results and holds the redirect until fetch accepts it.
module jump_redirect_arb #(
  parameter int WAYS    = 2,
  parameter int ADDR_W  = 32,
  parameter int AGE_W   = 2,
  parameter int EPOCH_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  jump_redirect_arb_if.slave bus
);
  logic [AGE_W-1:0]  way_age  [WAYS];
  logic [AGE_W-1:0]  way_rel  [WAYS];
  logic [ADDR_W-1:0] way_addr [WAYS];

  logic              cand_valid;
  logic [AGE_W-1:0]  cand_rel;
  logic [AGE_W-1:0]  cand_age;
  logic [ADDR_W-1:0] cand_addr;

  logic               pend_valid_q, pend_valid_d;
  logic [AGE_W-1:0]   pend_age_q, pend_age_d;
  logic [ADDR_W-1:0]  pend_addr_q, pend_addr_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;

  logic [AGE_W-1:0] pend_rel;
  logic             cand_load;
  logic             handshake;
  logic             eff_valid;
  logic [AGE_W-1:0] eff_rel;

  // Ages are compared relative to the head so that tag wrap-around orders correctly.
  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_way
      assign way_age[gi]  = bus.way_age_i[gi*AGE_W +: AGE_W];
      assign way_addr[gi] = bus.way_jumpAddr_i[gi*ADDR_W +: ADDR_W];
      assign way_rel[gi]  = way_age[gi] - bus.headAge_i;
    end
  endgenerate

  // Strict less-than keeps the lowest way index on equal ages.
  always_comb begin
    cand_valid = 1'b0;
    cand_rel   = '0;
    cand_age   = '0;
    cand_addr  = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (bus.way_jumpFlag_i[i] && (!cand_valid || way_rel[i] < cand_rel)) begin
        cand_valid = 1'b1;
        cand_rel   = way_rel[i];
        cand_age   = way_age[i];
        cand_addr  = way_addr[i];
      end
    end
  end

  assign pend_rel  = pend_age_q - bus.headAge_i;
  assign handshake = pend_valid_q && bus.redirect_ready_i;
  assign cand_load = !bus.flush_i && cand_valid && (!pend_valid_q || cand_rel < pend_rel);
  assign eff_valid = cand_load || pend_valid_q;
  assign eff_rel   = cand_load ? cand_rel : pend_rel;

  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_age_d   = pend_age_q;
    pend_addr_d  = pend_addr_q;
    epoch_d      = epoch_q;
    if (handshake) begin
      epoch_d = epoch_q + EPOCH_W'(1);
    end
    if (bus.flush_i) begin
      pend_valid_d = 1'b0;
    end else if (cand_load) begin
      pend_valid_d = 1'b1;
      pend_age_d   = cand_age;
      pend_addr_d  = cand_addr;
    end else if (handshake) begin
      pend_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid_q <= 1'b0;
      pend_age_q   <= '0;
      pend_addr_q  <= '0;
      epoch_q      <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_age_q   <= pend_age_d;
      pend_addr_q  <= pend_addr_d;
      epoch_q      <= epoch_d;
    end
  end

  // The winning way has rel equal to eff_rel, so it is never cleared.
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_clear
      assign bus.way_jumpClear_o[gi] = rst_n && (bus.flush_i || (eff_valid && (way_rel[gi] > eff_rel)));
    end
  endgenerate

  assign bus.redirect_valid_o = pend_valid_q;
  assign bus.redirect_addr_o  = pend_addr_q;
  assign bus.epoch_o          = epoch_q;
endmodule
